// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-tick divider, horizontal/vertical counters,
// registered sync/blanking outputs aligned with x/y, and a once-per-frame pulse.
module vga_sync_gen #(
  parameter int unsigned SCREEN_WIDTH = 10,
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned H_DISPLAY    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_DISPLAY    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter bit          SYNC_ACTIVE  = 1'b0
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  output logic                    p_tick,
  output logic [SCREEN_WIDTH-1:0] x,
  output logic [SCREEN_WIDTH-1:0] y,
  output logic                    video_on,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    frame_end
);

  localparam int unsigned W       = SCREEN_WIDTH;
  localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [W-1:0]     H_LAST   = W'(H_TOTAL - 1);
  localparam logic [W-1:0]     V_LAST   = W'(V_TOTAL - 1);
  localparam logic [W-1:0]     H_VIS    = W'(H_DISPLAY);
  localparam logic [W-1:0]     V_VIS    = W'(V_DISPLAY);
  localparam logic [W-1:0]     HS_FIRST = W'(H_DISPLAY + H_FRONT);
  localparam logic [W-1:0]     HS_LAST  = W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [W-1:0]     VS_FIRST = W'(V_DISPLAY + V_FRONT);
  localparam logic [W-1:0]     VS_LAST  = W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  // Reject parameter sets the counters cannot represent.
  generate
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
      $error("vga_sync_gen: CLK_DIV must be in 1..16");
    end
    if (((H_TOTAL - 1) >> W) != 0 || ((V_TOTAL - 1) >> W) != 0) begin : g_bad_width
      $error("vga_sync_gen: H_TOTAL-1/V_TOTAL-1 exceed SCREEN_WIDTH bits");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [W-1:0]     h_cnt, h_nxt;
  logic [W-1:0]     v_cnt, v_nxt;
  logic             tick_nxt, fe_nxt, von_nxt, hs_nxt, vs_nxt;

  // Next-state: the registered p_tick is the pixel enable for counters and outputs.
  always_comb begin
    div_nxt  = div_cnt + DIV_W'(1);
    h_nxt    = h_cnt;
    v_nxt    = v_cnt;
    von_nxt  = video_on;
    hs_nxt   = hsync;
    vs_nxt   = vsync;
    if (div_cnt == DIV_LAST) begin
      div_nxt = '0;
    end
    if (p_tick) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + W'(1);
      end else begin
        h_nxt = h_cnt + W'(1);
      end
    end
    tick_nxt = (div_nxt == DIV_LAST);
    fe_nxt   = tick_nxt && (h_nxt == H_LAST) && (v_nxt == V_LAST);
    if (p_tick) begin
      von_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
      hs_nxt  = ((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_nxt  = ((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      div_cnt   <= '0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      p_tick    <= 1'b0;
      frame_end <= 1'b0;
      video_on  <= 1'b0;
      hsync     <= ~SYNC_ACTIVE;
      vsync     <= ~SYNC_ACTIVE;
    end else begin
      div_cnt   <= div_nxt;
      h_cnt     <= h_nxt;
      v_cnt     <= v_nxt;
      p_tick    <= tick_nxt;
      frame_end <= fe_nxt;
      video_on  <= von_nxt;
      hsync     <= hs_nxt;
      vsync     <= vs_nxt;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default, reduced CLK_DIV=2, reduced CLK_DIV=1)
// checked every cycle against an arithmetic timing model, plus vectors and reset sequences.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_def = 1'b0, rst_red = 1'b0, rst_one = 1'b0;

  logic       p_def, von_def, hs_def, vs_def, fe_def;
  logic [9:0] x_def, y_def;
  logic       p_red, von_red, hs_red, vs_red, fe_red;
  logic [9:0] x_red, y_red;
  logic       p_one, von_one, hs_one, vs_one, fe_one;
  logic [9:0] x_one, y_one;

  vga_sync_gen u_def (
    .sys_clk(clk), .sys_rst_n(rst_def), .p_tick(p_def), .x(x_def), .y(y_def),
    .video_on(von_def), .hsync(hs_def), .vsync(vs_def), .frame_end(fe_def)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_red (
    .sys_clk(clk), .sys_rst_n(rst_red), .p_tick(p_red), .x(x_red), .y(y_red),
    .video_on(von_red), .hsync(hs_red), .vsync(vs_red), .frame_end(fe_red)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_one (
    .sys_clk(clk), .sys_rst_n(rst_one), .p_tick(p_one), .x(x_one), .y(y_one),
    .video_on(von_one), .hsync(hs_one), .vsync(vs_one), .frame_end(fe_one)
  );

  logic [24:0] pk_def, pk_red, pk_one;
  assign pk_def = {p_def, x_def, y_def, von_def, hs_def, vs_def, fe_def};
  assign pk_red = {p_red, x_red, y_red, von_red, hs_red, vs_red, fe_red};
  assign pk_one = {p_one, x_one, y_one, von_one, hs_one, vs_one, fe_one};

  // Clock edges seen since each instance left reset.
  int k_def = 0, k_red = 0, k_one = 0;
  always @(posedge clk or negedge rst_def) if (!rst_def) k_def <= 0; else k_def <= k_def + 1;
  always @(posedge clk or negedge rst_red) if (!rst_red) k_red <= 0; else k_red <= k_red + 1;
  always @(posedge clk or negedge rst_one) if (!rst_one) k_one <= 0; else k_one <= k_one + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Expected outputs after k edges: ticks land on k%d==d-1, each tick advances one pixel.
  function automatic logic [24:0] ref_out(input int k, input int d,
                                          input int hd, input int hf, input int hs, input int hb,
                                          input int vd, input int vf, input int vs, input int vb);
    int ht, vt, pix, xx, yy;
    logic tick, von, hsy, vsy, fe;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    if (k == 0) return {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    tick = ((k % d) == d - 1);
    pix  = (d == 1) ? k - 1 : k / d;
    xx   = pix % ht;
    yy   = (pix / ht) % vt;
    von  = (pix > 0) && (xx < hd) && (yy < vd);
    hsy  = !((xx >= hd + hf) && (xx < hd + hf + hs));
    vsy  = !((yy >= vd + vf) && (yy < vd + vf + vs));
    fe   = tick && (xx == ht - 1) && (yy == vt - 1);
    return {tick, 10'(xx), 10'(yy), von, hsy, vsy, fe};
  endfunction

  function automatic logic [24:0] exp_def(input int k);
    return ref_out(k, 4, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction
  function automatic logic [24:0] exp_red(input int k);
    return ref_out(k, 2, 8, 2, 2, 2, 6, 1, 1, 1);
  endfunction
  function automatic logic [24:0] exp_one(input int k);
    return ref_out(k, 1, 8, 2, 2, 2, 6, 1, 1, 1);
  endfunction

  localparam logic [24:0] RST_PK = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    cmp($sformatf("def model k=%0d", k_def), 32'(pk_def), 32'(exp_def(k_def)));
    cmp($sformatf("red model k=%0d", k_red), 32'(pk_red), 32'(exp_red(k_red)));
    cmp($sformatf("one model k=%0d", k_one), 32'(pk_one), 32'(exp_one(k_one)));
  endtask

  typedef struct {
    int         k;
    logic [9:0] x;
    logic [9:0] y;
    logic       p;
    logic       v;
    logic       hs;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl[NVEC];
  int   ti = 0;

  task automatic table_check();
    if (ti < NVEC && k_def == tbl[ti].k) begin
      cmp($sformatf("vector k=%0d {p,x,y,v,hs}", tbl[ti].k),
          32'({p_def, x_def, y_def, von_def, hs_def}),
          32'({tbl[ti].p, tbl[ti].x, tbl[ti].y, tbl[ti].v, tbl[ti].hs}));
      ti++;
    end
  endtask

  int  last_red = -1, last_one = -1;
  bit  after_red = 0, after_one = 0, mid_done = 0;
  int  hold = 0;
  int  fe_red_act = 0, fe_red_exp = 0, fe_one_act = 0, fe_one_exp = 0;
  int  wait_n, inst, hold_n;

  initial begin
    //          k     x       y      p     v     hs
    tbl[0]  = '{0,    10'd0,   10'd0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{3,    10'd0,   10'd0, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{4,    10'd1,   10'd0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{7,    10'd1,   10'd0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{8,    10'd2,   10'd0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{2559, 10'd639, 10'd0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{2560, 10'd640, 10'd0, 1'b0, 1'b0, 1'b1};
    tbl[7]  = '{2623, 10'd655, 10'd0, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{2624, 10'd656, 10'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{3007, 10'd751, 10'd0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{3008, 10'd752, 10'd0, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{3199, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{3200, 10'd0,   10'd1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{6400, 10'd0,   10'd2, 1'b0, 1'b1, 1'b1};

    repeat (3) begin
      @(negedge clk);
      check_all();
      table_check();
    end
    rst_def = 1'b1;
    rst_red = 1'b1;
    rst_one = 1'b1;

    // Free run, then an asynchronous reset of the default instance in the middle of hsync.
    for (int c = 0; c < 9400; c++) begin
      @(negedge clk);
      check_all();
      table_check();
      if (fe_red) begin
        if (last_red >= 0) cmp("red frame_end period", 32'(k_red - last_red), 32'd252);
        cmp("red frame_end xy", 32'({x_red, y_red}), 32'({10'd13, 10'd8}));
        last_red  = k_red;
        after_red = 1;
        fe_red_act++;
      end else if (after_red) begin
        cmp("red xy after frame_end", 32'({x_red, y_red}), 32'd0);
        after_red = 0;
      end
      if (fe_one) begin
        if (last_one >= 0) cmp("one frame_end period", 32'(k_one - last_one), 32'd126);
        cmp("one frame_end xy", 32'({x_one, y_one}), 32'({10'd13, 10'd8}));
        last_one  = k_one;
        after_one = 1;
        fe_one_act++;
      end else if (after_one) begin
        cmp("one xy after frame_end", 32'({x_one, y_one}), 32'd0);
        after_one = 0;
      end
      if (exp_red(k_red) & 25'd1) fe_red_exp++;
      if (exp_one(k_one) & 25'd1) fe_one_exp++;

      if (!mid_done && k_def == 9201) begin
        cmp("def before reset {x,y,hsync}", 32'({x_def, y_def, hs_def}),
            32'({10'd700, 10'd2, 1'b0}));
        #2 rst_def = 1'b0;
        #1 cmp("def async reset mid-hsync", 32'(pk_def), 32'(RST_PK));
        mid_done = 1;
        hold     = 3;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) rst_def = 1'b1;
      end
    end
    cmp("vectors applied", 32'(ti), 32'(NVEC));
    cmp("mid-hsync reset reached", 32'(mid_done), 32'd1);
    cmp("red frame_end count", 32'(fe_red_act), 32'(fe_red_exp));
    cmp("one frame_end count", 32'(fe_one_act), 32'(fe_one_exp));

    // Random asynchronous resets on random instances at random sub-cycle offsets.
    for (int it = 0; it < 40; it++) begin
      wait_n = int'($urandom_range(400, 20));
      inst   = int'($urandom_range(2, 0));
      hold_n = int'($urandom_range(3, 1));
      repeat (wait_n) begin
        @(negedge clk);
        check_all();
      end
      #($urandom_range(3, 1));
      case (inst)
        0:       rst_def = 1'b0;
        1:       rst_red = 1'b0;
        default: rst_one = 1'b0;
      endcase
      #1;
      case (inst)
        0:       cmp("def random async reset", 32'(pk_def), 32'(RST_PK));
        1:       cmp("red random async reset", 32'(pk_red), 32'(RST_PK));
        default: cmp("one random async reset", 32'(pk_one), 32'(RST_PK));
      endcase
      repeat (hold_n) begin
        @(negedge clk);
        check_all();
      end
      case (inst)
        0:       rst_def = 1'b1;
        1:       rst_red = 1'b1;
        default: rst_one = 1'b1;
      endcase
    end
    repeat (600) begin
      @(negedge clk);
      check_all();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
